// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pops words from the TX FIFO and sends them as
// start bit, LSB-first data, optional parity and one or two stop bits.
module uart_tx_fifo_reader #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              tx_en,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);

    // FIFO read handshake: fifo_rd_en is a one-cycle pop strobe issued only
    // after fifo_empty was sampled low; fifo_data is valid the following cycle.

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic             ODD_INV   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  baud_cnt, baud_next;
    logic [IDX_W-1:0]  bit_idx, idx_next;
    logic [DATA_W-1:0] shift, shift_next;
    logic              parity_bit, parity_next;
    logic              tx_next;
    logic              done_next;
    logic              bit_end;
    logic              start_ok;

    assign bit_end    = (baud_cnt == BAUD_LAST);
    assign start_ok   = tx_en && !fifo_empty;
    assign fifo_rd_en = (state == FETCH);
    assign busy       = (state != IDLE);
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (n_reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_next;
            bit_idx    <= idx_next;
            shift      <= shift_next;
            parity_bit <= parity_next;
            tx         <= tx_next;
            done       <= done_next;
        end
    end

    always_comb begin
        state_next  = state;
        baud_next   = baud_cnt;
        idx_next    = bit_idx;
        shift_next  = shift;
        parity_next = parity_bit;
        tx_next     = tx;
        done_next   = 1'b0;

        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (start_ok) state_next = FETCH;
            end
            FETCH: begin
                state_next = LOAD;
            end
            LOAD: begin
                shift_next  = fifo_data;
                parity_next = (^fifo_data) ^ ODD_INV;
                tx_next     = 1'b0;
                baud_next   = '0;
                idx_next    = '0;
                state_next  = START;
            end
            START: begin
                if (bit_end) begin
                    tx_next    = shift[0];
                    baud_next  = '0;
                    idx_next   = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (bit_idx == DATA_LAST) begin
                        idx_next = '0;
                        if (PARITY_EN != 0) begin
                            tx_next    = parity_bit;
                            state_next = PARITY;
                        end else begin
                            tx_next    = 1'b1;
                            state_next = STOP;
                        end
                    end else begin
                        shift_next = {1'b0, shift[DATA_W-1:1]};
                        tx_next    = shift[1];
                        idx_next   = bit_idx + IDX_W'(1);
                    end
                end else begin
                    baud_next = baud_cnt + CNT_W'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    tx_next    = 1'b1;
                    baud_next  = '0;
                    idx_next   = '0;
                    state_next = STOP;
                end else begin
                    baud_next = baud_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_next = '0;
                    // bit_idx doubles as the stop-bit counter
                    if (bit_idx == STOP_LAST) begin
                        idx_next   = '0;
                        done_next  = 1'b1;
                        state_next = start_ok ? FETCH : IDLE;
                    end else begin
                        idx_next = bit_idx + IDX_W'(1);
                    end
                end else begin
                    baud_next = baud_cnt + CNT_W'(1);
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Directed bench for uart_tx_fifo_reader: three configurations fed by
// small FIFO models, every serial cycle compared against expected levels.
module tb_uart_tx_fifo_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       n_reset;
    logic       tx_en0, tx_en1, tx_en2;
    logic       empty0, empty1, empty2;
    logic [7:0] data0 = 8'h00, data1 = 8'h00, data2 = 8'h00;
    logic       rd0, rd1, rd2;
    logic       tx0, tx1, tx2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic [2:0] st0, st1, st2;

    logic [7:0] mem0[32], mem1[32], mem2[32];
    int wr0 = 0, wr1 = 0, wr2 = 0;
    int rp0 = 0, rp1 = 0, rp2 = 0;
    int pops0 = 0, pops1 = 0, pops2 = 0;
    logic perr0 = 1'b0, perr1 = 1'b0, perr2 = 1'b0;

    int checks = 0;
    int errors = 0;

    assign empty0 = (rp0 == wr0);
    assign empty1 = (rp1 == wr1);
    assign empty2 = (rp2 == wr2);

    uart_tx_fifo_reader #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .n_reset(n_reset), .tx_en(tx_en0), .fifo_data(data0), .fifo_empty(empty0),
        .fifo_rd_en(rd0), .tx(tx0), .busy(busy0), .done(done0), .dbg_state(st0));
    uart_tx_fifo_reader #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
        .clk(clk), .n_reset(n_reset), .tx_en(tx_en1), .fifo_data(data1), .fifo_empty(empty1),
        .fifo_rd_en(rd1), .tx(tx1), .busy(busy1), .done(done1), .dbg_state(st1));
    uart_tx_fifo_reader #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
        .clk(clk), .n_reset(n_reset), .tx_en(tx_en2), .fifo_data(data2), .fifo_empty(empty2),
        .fifo_rd_en(rd2), .tx(tx2), .busy(busy2), .done(done2), .dbg_state(st2));

    // FIFO models: registered data_out, pop while empty flags an error
    always @(posedge clk) begin
        if (rd0) begin
            if (rp0 == wr0) perr0 <= 1'b1;
            else begin data0 <= mem0[rp0]; rp0 <= rp0 + 1; pops0 <= pops0 + 1; end
        end
        if (rd1) begin
            if (rp1 == wr1) perr1 <= 1'b1;
            else begin data1 <= mem1[rp1]; rp1 <= rp1 + 1; pops1 <= pops1 + 1; end
        end
        if (rd2) begin
            if (rp2 == wr2) perr2 <= 1'b1;
            else begin data2 <= mem2[rp2]; rp2 <= rp2 + 1; pops2 <= pops2 + 1; end
        end
    end

    function automatic logic get_tx(input int i);
        case (i) 0: return tx0; 1: return tx1; default: return tx2; endcase
    endfunction
    function automatic logic get_rd(input int i);
        case (i) 0: return rd0; 1: return rd1; default: return rd2; endcase
    endfunction
    function automatic logic get_busy(input int i);
        case (i) 0: return busy0; 1: return busy1; default: return busy2; endcase
    endfunction
    function automatic logic get_done(input int i);
        case (i) 0: return done0; 1: return done1; default: return done2; endcase
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input int i, input logic [7:0] d);
        case (i)
            0: begin mem0[wr0] = d; wr0 = wr0 + 1; end
            1: begin mem1[wr1] = d; wr1 = wr1 + 1; end
            default: begin mem2[wr2] = d; wr2 = wr2 + 1; end
        endcase
    endtask

    task automatic set_en(input int i, input logic v);
        case (i) 0: tx_en0 = v; 1: tx_en1 = v; default: tx_en2 = v; endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge of the FETCH cycle; walks the whole frame cycle by cycle
    task automatic check_frame(input string name, input int i, input logic [7:0] d,
                               input int pe, input logic pbit, input int stops,
                               input logic more, input int drop_at);
        logic lvl[$];
        lvl.push_back(1'b0);
        for (int k = 0; k < 8; k++) lvl.push_back(d[k]);
        if (pe != 0) lvl.push_back(pbit);
        for (int s = 0; s < stops; s++) lvl.push_back(1'b1);

        chk({name, "_fetch_rd"}, get_rd(i), 1);
        chk({name, "_fetch_busy"}, get_busy(i), 1);
        step();
        chk({name, "_load_rd"}, get_rd(i), 0);
        chk({name, "_load_tx"}, get_tx(i), 1);
        for (int b = 0; b < lvl.size(); b++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                if (b == drop_at && c == 0) set_en(i, 1'b0);
                chk($sformatf("%s_b%0d_c%0d_tx", name, b, c), get_tx(i), lvl[b]);
                chk($sformatf("%s_b%0d_c%0d_done", name, b, c), get_done(i), 0);
                chk($sformatf("%s_b%0d_c%0d_rd", name, b, c), get_rd(i), 0);
            end
        end
        step();
        chk({name, "_end_done"}, get_done(i), 1);
        chk({name, "_end_tx"}, get_tx(i), 1);
        chk({name, "_end_busy"}, get_busy(i), more);
        chk({name, "_end_rd"}, get_rd(i), more);
    endtask

    initial begin
        n_reset = 1'b1;
        tx_en0 = 1'b0; tx_en1 = 1'b0; tx_en2 = 1'b0;
        repeat (3) step();
        chk("rst_tx", tx0, 1);
        chk("rst_rd", rd0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_state", st0, 0);
        n_reset = 1'b0;
        repeat (2) step();
        chk("idle_busy", busy0, 0);

        // empty FIFO with tx_en high: nothing happens
        tx_en0 = 1'b1;
        for (int n = 0; n < 100; n++) begin
            step();
            chk($sformatf("empty_rd_%0d", n), rd0, 0);
            chk($sformatf("empty_tx_%0d", n), tx0, 1);
            chk($sformatf("empty_busy_%0d", n), busy0, 0);
        end

        // single frame 0xA5
        push(0, 8'hA5);
        step();
        check_frame("single", 0, 8'hA5, 0, 1'b0, 1, 1'b0, -1);
        chk("single_pops", pops0, 1);
        step();
        chk("single_after_done", done0, 0);

        // back-to-back 0x00 then 0xFF
        push(0, 8'h00);
        push(0, 8'hFF);
        step();
        check_frame("b2b_00", 0, 8'h00, 0, 1'b0, 1, 1'b1, -1);
        check_frame("b2b_ff", 0, 8'hFF, 0, 1'b0, 1, 1'b0, -1);
        chk("b2b_pops", pops0, 3);

        // parity: even 0x07, odd 0x07 then odd 0x03 with two stop bits
        push(1, 8'h07);
        set_en(1, 1'b1);
        step();
        check_frame("par_even07", 1, 8'h07, 1, 1'b1, 1, 1'b0, -1);
        chk("par_even_pops", pops1, 1);
        push(2, 8'h07);
        push(2, 8'h03);
        set_en(2, 1'b1);
        step();
        check_frame("par_odd07", 2, 8'h07, 1, 1'b0, 2, 1'b1, -1);
        check_frame("par_odd03", 2, 8'h03, 1, 1'b1, 2, 1'b0, -1);
        chk("par_odd_pops", pops2, 2);

        // tx_en dropped during data bit 2 with a second byte queued
        push(0, 8'h3C);
        push(0, 8'h5A);
        step();
        check_frame("drop", 0, 8'h3C, 0, 1'b0, 1, 1'b0, 3);
        for (int n = 0; n < 20; n++) begin
            step();
            chk($sformatf("drop_idle_rd_%0d", n), rd0, 0);
            chk($sformatf("drop_idle_busy_%0d", n), busy0, 0);
        end
        chk("drop_pops", pops0, 4);
        set_en(0, 1'b1);
        step();
        check_frame("resume", 0, 8'h5A, 0, 1'b0, 1, 1'b0, -1);
        chk("resume_pops", pops0, 5);

        // reset during data bit 3 of 0x96
        push(0, 8'h96);
        step();
        chk("rstmid_fetch_rd", rd0, 1);
        repeat (18) step();
        chk("rstmid_bit3_tx", tx0, 0);
        step();
        n_reset = 1'b1;
        step();
        chk("rstmid_tx", tx0, 1);
        chk("rstmid_busy", busy0, 0);
        chk("rstmid_done", done0, 0);
        chk("rstmid_rd", rd0, 0);
        chk("rstmid_state", st0, 0);
        push(0, 8'hC3);
        step();
        chk("rstmid_hold_rd", rd0, 0);
        chk("rstmid_hold_busy", busy0, 0);
        n_reset = 1'b0;
        step();
        check_frame("after_rst", 0, 8'hC3, 0, 1'b0, 1, 1'b0, -1);
        chk("after_rst_pops", pops0, 7);

        chk("no_empty_pop0", perr0, 0);
        chk("no_empty_pop1", perr1, 0);
        chk("no_empty_pop2", perr2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
